keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Sits directly downstream of the 4x3 keypad scanner and consumes its 12-bit one-hot key_data bus.
- Filters glitches and scan transients, detects press events, and encodes each key to a 4-bit code.
- Assembles up to DIGITS decimal digits into a BCD entry buffer: '*' = backspace, '#' = enter.
- Delivers the committed value to the application logic with a one-cycle strobe.

Parameters:
- DIGITS, 4, number of BCD digits held in the entry buffer (1..8).
- STABLE_CNT, 250000, clk cycles a key_data pattern must stay unchanged before it is accepted (5 ms at 50 MHz).
- CNT_W, $clog2(STABLE_CNT+1), stability counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, the same clock that drives the scanner's divider.
- rst  in  1  asynchronous, active-low reset.
- key_data  in  12  one-hot key bus from the scanner. Bits 0..8 = keys 1..9, bit9 = '*', bit10 = '0', bit11 = '#'. All-zero = no key.
- clr  in  1  synchronous clear of the entry buffer.
- key_valid  out  1  one-cycle pulse per accepted key press.
- key_code  out  4  code of the last accepted key. 0..9 = digits, 4'hA = '*', 4'hB = '#'.
- entry_buf  out  4*DIGITS  live BCD buffer, least significant digit in [3:0].
- digit_cnt  out  4  number of digits currently in the buffer (0..DIGITS).
- overflow  out  1  one-cycle pulse when a digit is rejected because the buffer is full.
- entry_value  out  4*DIGITS  value committed by the last '#'.
- enter_valid  out  1  one-cycle pulse when entry_value is updated.

Behaviour:
- Reset: rst low asynchronously zeroes all registers and outputs, including the synchronizers, stability counter and the stable pattern. FSM enters IDLE.
- Synchronizer: key_data passes through 2 flops (it is launched from the divided scan clock).
- Stability filter:
  - The candidate register captures the synchronized sample. Any mismatch reloads the candidate and zeroes the counter.
  - On a match, the counter increments, saturating at STABLE_CNT.
  - When the counter reaches STABLE_CNT, stable <= candidate.
  - A non-one-hot nonzero candidate is accepted as stable = 0.
- Press FSM:
  - IDLE: stable == 0. A transition to a nonzero stable value goes to PRESSED and issues a key event.
  - PRESSED: no further events. When stable returns to 0, go to IDLE.
  - A direct change from one key to another without passing through 0 issues no event.
- Key event: key_valid is high for exactly 1 cycle and key_code updates in that same cycle. Latency from a key_data change to key_valid is STABLE_CNT+3 clk cycles, exact.
- Buffer update, registered in the key_valid cycle and visible the next cycle:
  - Digit, digit_cnt < DIGITS: entry_buf <= {entry_buf[4*DIGITS-5:0], code}; digit_cnt++.
  - Digit, digit_cnt == DIGITS: buffer unchanged; overflow pulses 1 cycle.
  - '*', digit_cnt > 0: entry_buf <= entry_buf >> 4; digit_cnt--. With digit_cnt == 0 it has no effect.
  - '#': entry_value <= entry_buf; enter_valid pulses; entry_buf <= 0; digit_cnt <= 0. With an empty buffer it commits 0.
- clr: zeroes entry_buf and digit_cnt. It wins over a same-cycle key event: that event still pulses key_valid, but its buffer action is dropped. It does not alter entry_value.
- Reset mid-operation: a press held through reset release yields no event until stable passes through 0 and back. To guarantee this, the FSM leaves reset in PRESSED if the first stable value is nonzero.

Decomposition:
- keypad_pkg:
  - key code constants KEY_STAR = 4'hA and KEY_HASH = 4'hB.
  - one-hot bit index constants for '*', '0' and '#'.
  - a function mapping one-hot 12 bits to a 4-bit code.
- Sub-module key_debounce: synchronizer plus stability filter. Parameter STABLE_CNT; ports clk, rst, key_data in, stable out.
- keypad_entry instantiates key_debounce and holds the press FSM and the buffer.

Test Plan (STABLE_CNT=4, DIGITS=4):
- Reset, then hold key_data = 12'h001 for 20 cycles, then 0 -> key_valid exactly once, at cycle 7; key_code = 1; entry_buf = 16'h0001; digit_cnt = 1.
- Press 1, 2, 3, 4, 5, each followed by a release -> entry_buf = 16'h1234; key 5 gives an overflow pulse; digit_cnt = 4.
- With buffer 16'h1234, press '*' (12'h200) then '#' (12'h800) -> after '*' entry_buf = 16'h0123; after '#' entry_value = 16'h0123, enter_valid for 1 cycle, entry_buf = 0, digit_cnt = 0.
- Key 7 (12'h040) with 2-cycle glitches to 0 every 3 cycles -> no key_valid. Holding it for 10 cycles -> one event, key_code = 7.
- Invalid pattern 12'h003 held for 20 cycles -> no key_valid. Key 0 (12'h400) -> key_code = 0; entry_buf shifts in 0.
- Assert clr in the same cycle as the key_valid for key 9 -> key_valid = 1, key_code = 9, entry_buf = 0, digit_cnt = 0. Deassert rst mid-hold of key 3 -> no event until release and re-press.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and key encoding helpers for the keypad entry block.
package keypad_pkg;

  localparam int KEY_W = 12;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  // One-hot bit positions of the non-numeric-order keys on the scanner bus.
  localparam int IDX_STAR = 9;
  localparam int IDX_ZERO = 10;
  localparam int IDX_HASH = 11;

  // INIT holds off key events until the filter has produced its first stable value.
  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_PRESSED
  } press_state_e;

  // Map a one-hot key bus to its 4-bit code; bits 0..8 are keys 1..9.
  function automatic logic [3:0] key_encode(input logic [KEY_W-1:0] oh);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (oh[i]) code = 4'(i + 1);
    end
    if (oh[IDX_STAR]) code = KEY_STAR;
    if (oh[IDX_ZERO]) code = 4'd0;
    if (oh[IDX_HASH]) code = KEY_HASH;
    return code;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stability filter: a pattern must persist
// for STABLE_CNT matching samples before it becomes the stable value.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int STABLE_CNT = 250000,
  localparam int CNT_W = $clog2(STABLE_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_data,
  output logic [KEY_W-1:0] stable,
  output logic             settled
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

  logic [KEY_W-1:0] sync1_q, sync2_q;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] stable_q, stable_d;
  logic             settled_q, settled_d;

  // Synchronize the scan-clock-launched bus into this domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_data;
      sync2_q <= sync1_q;
    end
  end

  // Reload on any change, count matching samples, publish once the count saturates.
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    settled_d = settled_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) begin
        // Multi-key chords and other non-one-hot patterns read as "no key".
        stable_d  = is_onehot(cand_q) ? cand_q : '0;
        settled_d = 1'b1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      settled_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      settled_q <= settled_d;
    end
  end

  assign stable  = stable_q;
  assign settled = settled_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounce, press detection, key encoding and a BCD entry
// buffer with backspace ('*') and enter ('#').
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_W-1:0]    key_data,
  input  logic                clr,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] entry_buf,
  output logic [3:0]          digit_cnt,
  output logic                overflow,
  output logic [4*DIGITS-1:0] entry_value,
  output logic                enter_valid
);

  localparam int BUF_W = 4 * DIGITS;

  logic [KEY_W-1:0] stable;
  logic             settled;
  logic [3:0]       new_code;

  press_state_e state_q, state_d;
  logic [3:0]       code_q;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BUF_W-1:0] val_q, val_d;
  logic             ovf_q, ovf_d;
  logic             ent_q, ent_d;

  key_debounce #(.STABLE_CNT(STABLE_CNT)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .key_data (key_data),
    .stable   (stable),
    .settled  (settled)
  );

  assign new_code = key_encode(stable);

  // Press FSM: one event per 0 -> key transition; a key already down when the
  // filter first settles is treated as held so it cannot fire after reset.
  always_comb begin
    state_d   = state_q;
    key_valid = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (settled) state_d = (stable != '0) ? ST_PRESSED : ST_IDLE;
      end
      ST_IDLE: begin
        if (stable != '0) begin
          key_valid = 1'b1;
          state_d   = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (stable == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Buffer edits for the current key event; clr overrides the event's action.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    val_d = val_q;
    ovf_d = 1'b0;
    ent_d = 1'b0;
    if (clr) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (key_valid) begin
      if (new_code <= 4'd9) begin
        if (cnt_q < 4'(DIGITS)) begin
          buf_d = (buf_q << 4) | BUF_W'(new_code);
          cnt_d = cnt_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (new_code == KEY_STAR) begin
        if (cnt_q != '0) begin
          buf_d = buf_q >> 4;
          cnt_d = cnt_q - 4'd1;
        end
      end else begin
        val_d = buf_q;
        ent_d = 1'b1;
        buf_d = '0;
        cnt_d = '0;
      end
    end
  end

  // FSM, last key code and buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      code_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      ovf_q   <= 1'b0;
      ent_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (key_valid) code_q <= new_code;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      ovf_q   <= ovf_d;
      ent_q   <= ent_d;
    end
  end

  // The fresh code is shown in the event cycle itself, then held.
  assign key_code    = key_valid ? new_code : code_q;
  assign entry_buf   = buf_q;
  assign digit_cnt   = cnt_q;
  assign overflow    = ovf_q;
  assign entry_value = val_q;
  assign enter_valid = ent_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_keypad_entry;

  localparam int DIGITS = 4;
  localparam int SCNT   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] key_data = '0;
  logic        clr = 1'b0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_buf;
  logic [3:0]  digit_cnt;
  logic        overflow;
  logic [15:0] entry_value;
  logic        enter_valid;

  int n_chk  = 0;
  int n_fail = 0;

  keypad_entry #(.DIGITS(DIGITS), .STABLE_CNT(SCNT)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_data    (key_data),
    .clr         (clr),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .entry_buf   (entry_buf),
    .digit_cnt   (digit_cnt),
    .overflow    (overflow),
    .entry_value (entry_value),
    .enter_valid (enter_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A value becomes stable once the same bus value has been seen on SCNT+1
  // consecutive clock edges; it shows two edges later (synchronizer depth).
  // An event is a 0 -> key change of the stable value, except for the first
  // value the filter ever settles on after reset.
  logic [11:0] hist[$];
  logic [11:0] st_m   = '0;
  bit          set_m  = 0;
  bit          kv_m   = 0;
  logic [3:0]  code_m = '0;
  int          dq[$];
  logic [15:0] ev_m   = '0;
  bit          env_m  = 0;
  bit          ovf_m  = 0;

  function automatic logic [3:0] enc_m(input logic [11:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) begin
        if (i < 9) c = 4'(i + 1);
        else if (i == 9) c = 4'hA;
        else if (i == 10) c = 4'h0;
        else c = 4'hB;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] buf_val();
    logic [15:0] v;
    v = '0;
    foreach (dq[i]) v = (v << 4) | 16'(dq[i]);
    return v;
  endfunction

  initial begin
    hist = '{12'h0, 12'h0, 12'h0};
    forever begin
      @(posedge clk);
      if (!rst) begin
        hist  = '{12'h0, 12'h0, 12'h0};
        st_m  = '0;
        set_m = 0;
        kv_m  = 0;
        code_m = '0;
        dq.delete();
        ev_m  = '0;
        env_m = 0;
        ovf_m = 0;
      end else begin
        env_m = 0;
        ovf_m = 0;
        if (clr) dq.delete();
        else if (kv_m) begin
          if (code_m <= 4'd9) begin
            if (dq.size() < DIGITS) dq.push_back(int'(code_m));
            else ovf_m = 1;
          end else if (code_m == 4'hA) begin
            if (dq.size() > 0) void'(dq.pop_back());
          end else begin
            ev_m  = buf_val();
            env_m = 1;
            dq.delete();
          end
        end
        hist.push_back(key_data);
        if (hist.size() > SCNT + 3) void'(hist.pop_front());
        kv_m = 0;
        if (hist.size() == SCNT + 3) begin
          bit same;
          logic [11:0] nv;
          same = 1;
          for (int i = 1; i <= SCNT; i++) if (hist[i] != hist[0]) same = 0;
          if (same) begin
            nv = ($countones(hist[0]) == 1) ? hist[0] : 12'h0;
            if (set_m && st_m == 0 && nv != 0) begin
              kv_m   = 1;
              code_m = enc_m(nv);
            end
            st_m  = nv;
            set_m = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and event counters ----------------
  int kv_cnt = 0, ovf_cnt = 0, ent_cnt = 0;
  logic [3:0] last_code = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("key_valid",   32'(key_valid),   32'(kv_m));
        chk("key_code",    32'(key_code),    32'(code_m));
        chk("entry_buf",   32'(entry_buf),   32'(buf_val()));
        chk("digit_cnt",   32'(digit_cnt),   32'(dq.size()));
        chk("overflow",    32'(overflow),    32'(ovf_m));
        chk("entry_value", 32'(entry_value), 32'(ev_m));
        chk("enter_valid", 32'(enter_valid), 32'(env_m));
        if (key_valid) begin
          kv_cnt++;
          last_code = key_code;
        end
        if (overflow) ovf_cnt++;
        if (enter_valid) ent_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [11:0] k, input int hold, input int gap);
    key_data = k;
    cyc(hold);
    key_data = '0;
    cyc(gap);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  int base, first_at, hits;

  initial begin
    cyc(3);
    rst = 1'b1;
    chk("reset digit_cnt", 32'(digit_cnt), 32'd0);
    chk("reset entry_val", 32'(entry_value), 32'd0);
    cyc(10);

    // First press: exact latency SCNT+3 and a single event.
    key_data = 12'h001;
    first_at = -1;
    hits = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc(1);
      if (key_valid) begin
        hits++;
        if (first_at < 0) first_at = n;
      end
    end
    key_data = '0;
    cyc(12);
    chk("first latency", 32'(first_at), 32'd7);
    chk("first count",   32'(hits), 32'd1);
    chk("first code",    32'(last_code), 32'd1);
    chk("first buf",     32'(entry_buf), 32'h0001);
    chk("first cnt",     32'(digit_cnt), 32'd1);

    // Fill past capacity.
    pulse_clr();
    base = ovf_cnt;
    for (int d = 0; d < 5; d++) press(12'h001 << d, 10, 10);
    chk("fill buf",  32'(entry_buf), 32'h1234);
    chk("fill cnt",  32'(digit_cnt), 32'd4);
    chk("fill ovf",  32'(ovf_cnt - base), 32'd1);

    // Backspace then enter.
    press(12'h200, 10, 10);
    chk("bksp buf", 32'(entry_buf), 32'h0123);
    base = ent_cnt;
    press(12'h800, 10, 10);
    chk("enter value", 32'(entry_value), 32'h0123);
    chk("enter pulses", 32'(ent_cnt - base), 32'd1);
    chk("enter buf", 32'(entry_buf), 32'h0);
    chk("enter cnt", 32'(digit_cnt), 32'd0);

    // Glitchy key 7 never settles; a clean hold does.
    base = kv_cnt;
    for (int r = 0; r < 6; r++) begin
      key_data = 12'h040; cyc(3);
      key_data = 12'h000; cyc(2);
    end
    cyc(10);
    chk("glitch none", 32'(kv_cnt - base), 32'd0);
    press(12'h040, 10, 10);
    chk("key7 event", 32'(kv_cnt - base), 32'd1);
    chk("key7 code",  32'(last_code), 32'd7);

    // Invalid chord is ignored; key 0 shifts in a zero digit.
    base = kv_cnt;
    press(12'h003, 20, 10);
    chk("chord none", 32'(kv_cnt - base), 32'd0);
    press(12'h400, 10, 10);
    chk("key0 code", 32'(last_code), 32'd0);
    chk("key0 buf",  32'(entry_buf), 32'h0070);
    chk("key0 cnt",  32'(digit_cnt), 32'd2);

    // clr in the event cycle of key 9.
    key_data = 12'h100;
    hits = 0;
    for (int n = 0; n < 20 && hits == 0; n++) begin
      cyc(1);
      if (key_valid) begin
        hits = 1;
        chk("clr code", 32'(key_code), 32'd9);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
      end
    end
    chk("clr event seen", 32'(hits), 32'd1);
    chk("clr buf", 32'(entry_buf), 32'h0);
    chk("clr cnt", 32'(digit_cnt), 32'd0);
    chk("clr keeps value", 32'(entry_value), 32'h0123);
    key_data = '0;
    cyc(10);

    // Reset while key 3 is held.
    key_data = 12'h004;
    cyc(12);
    do_reset();
    base = kv_cnt;
    cyc(20);
    chk("held thru rst", 32'(kv_cnt - base), 32'd0);
    key_data = '0;
    cyc(15);
    chk("release no evt", 32'(kv_cnt - base), 32'd0);
    press(12'h004, 10, 10);
    chk("repress evt",  32'(kv_cnt - base), 32'd1);
    chk("repress code", 32'(last_code), 32'd3);

    // Randomized phase, checked by the per-cycle compare.
    for (int it = 0; it < 250; it++) begin
      int r, sel, hold;
      logic [11:0] k;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 15);
        if (sel < 12) k = 12'h001 << sel;
        else if (sel == 12) k = 12'(($urandom() & 12'hFFF) | 12'h801);
        else k = '0;
        hold = $urandom_range(1, 10);
        key_data = k;
        for (int c = 0; c < hold; c++) begin
          clr = ($urandom_range(0, 19) == 0);
          cyc(1);
        end
        clr = 1'b0;
      end
    end
    key_data = '0;
    cyc(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
